// File: rtl/adder_serial_nibble.sv
`default_nettype none
// ============================================================================
//  Module   : adder_serial_nibble (with helper slice adder_4bit)
//  Brief    : Multi-cycle WIDTH-bit add/subtract unit built around a single
//             4-bit ripple slice. Operands are latched on an accepted start
//             and one nibble is processed per cycle, LSB first. The carry is
//             chained through a register and sum nibbles are collected into
//             the result register.
//  Macro    : ADDER_SERIAL_FLAGS_EN - adds registered zero/negative outputs.
//  Ports    : clk, rst_n (async, active low)
//             start, sub, a, b       - request and operands (sampled when idle)
//             busy                   - high while nibbles are being processed
//             done                   - one-cycle pulse, result/flags valid
//             result                 - sum/difference, held until next accept
//             carry_out, overflow    - MSB carry (sub: 1 = no borrow), signed ovf
//             zero, negative         - result flags (macro builds only)
//  Revision : 1.0 - initial release
// ============================================================================

// 4-bit ripple slice: sum, carry out and signed overflow of its top bit.
module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout,
    output logic       o_ovf
);
    logic [4:0] w_full;
    logic [3:0] w_low;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    // Sum of the lower three bits: its bit 3 is the carry into bit 3.
    assign w_low  = {1'b0, i_a[2:0]} + {1'b0, i_b[2:0]} + {3'b000, i_cin};

    assign o_sum  = w_full[3:0];
    assign o_cout = w_full[4];
    assign o_ovf  = w_low[3] ^ w_full[4];
endmodule

module adder_serial_nibble #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
`ifdef ADDER_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative
`endif
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NIB - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_carry_out;
    logic             r_overflow;

    logic [3:0]       w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result_next;
    logic [CNT_W+1:0] w_base;

    // Bit offset of the nibble being processed this cycle.
    assign w_base = {r_cnt, 2'b00};

    adder_4bit u_slice (
        .i_a    (r_a[w_base +: 4]),
        .i_b    (r_b[w_base +: 4]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    // Result with the current nibble merged in; also feeds the zero flag so
    // it reflects the complete result on the final nibble.
    always_comb begin
        w_result_next = r_result;
        w_result_next[w_base +: 4] = w_sum;
    end

`ifdef ADDER_SERIAL_FLAGS_EN
    logic r_zero;
    logic r_negative;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef ADDER_SERIAL_FLAGS_EN
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry.
                        r_a         <= a;
                        r_b         <= sub ? ~b : b;
                        r_carry     <= sub;
                        r_cnt       <= '0;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_overflow  <= 1'b0;
`ifdef ADDER_SERIAL_FLAGS_EN
                        r_zero      <= 1'b0;
                        r_negative  <= 1'b0;
`endif
                        r_busy      <= 1'b1;
                        r_state     <= c_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_cout;
                    if (r_cnt == c_LAST) begin
                        r_cnt       <= '0;
                        r_carry_out <= w_cout;
                        r_overflow  <= w_ovf;
`ifdef ADDER_SERIAL_FLAGS_EN
                        r_zero      <= (w_result_next == '0);
                        r_negative  <= w_result_next[WIDTH-1];
`endif
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
`ifdef ADDER_SERIAL_FLAGS_EN
    assign zero      = r_zero;
    assign negative  = r_negative;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_serial_nibble.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_serial_nibble
//  Brief    : Scoreboard bench for adder_serial_nibble (WIDTH=32). Stimulus
//             pushes hand-computed expected responses; a monitor pops and
//             compares on every done pulse, including done latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_serial_nibble;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
`ifdef ADDER_SERIAL_FLAGS_EN
    logic             zero;
    logic             negative;
`endif

    adder_serial_nibble #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
`ifdef ADDER_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        int               t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done cycle consumes exactly one expected entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result",    result,           mon_e.res);
                chk("carry_out", 32'(carry_out),   32'(mon_e.co));
                chk("overflow",  32'(overflow),    32'(mon_e.ov));
                chk("latency",   32'(cyc - mon_e.t), 32'd9);
`ifdef ADDER_SERIAL_FLAGS_EN
                chk("zero",      32'(zero),        32'(mon_e.res == '0));
                chk("negative",  32'(negative),    32'(mon_e.res[WIDTH-1]));
`endif
            end
        end
    end

    // Issue one op with a single-cycle start; returns at the first RUN cycle.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic [31:0] eres, input logic eco, input logic eov);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        e.res = eres; e.co = eco; e.ov = eov; e.t = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_run",      32'(busy),      32'd1);
        chk("result_cleared",   result,         32'd0);
        chk("carry_cleared",    32'(carry_out), 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e2;
        int   n;
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_done",   32'(done),      32'd0);
        chk("rst_result", result,         32'd0);
        chk("rst_carry",  32'(carry_out), 32'd0);
        chk("rst_ovf",    32'(overflow),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic adds, boundary overflow/wrap, subtraction.
        issue(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
        wait_drain();
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        wait_drain();
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        wait_drain();
        issue(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        wait_drain();
        issue(32'h00001234, 32'h00001234, 1'b1, 32'h00000000, 1'b1, 1'b0);
        wait_drain();
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0);
        wait_drain();

        // Start during RUN ignored; start held through DONE accepted.
        issue(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 32'h80000000; b = 32'h00000001; sub = 1'b1; start = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen_for_held_start", 32'(done), 32'd1);
        e2.res = 32'h7FFFFFFF; e2.co = 1'b1; e2.ov = 1'b1; e2.t = cyc;
        sb.push_back(e2);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_held_start", 32'(busy), 32'd1);
        wait_drain();

        // Asynchronous reset in the middle of RUN.
        issue(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("partial_result", result, 32'h00000333);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   32'(busy),      32'd0);
        chk("arst_done",   32'(done),      32'd0);
        chk("arst_result", result,         32'd0);
        chk("arst_carry",  32'(carry_out), 32'd0);
        chk("arst_ovf",    32'(overflow),  32'd0);
`ifdef ADDER_SERIAL_FLAGS_EN
        chk("arst_zero",   32'(zero),      32'd0);
        chk("arst_neg",    32'(negative),  32'd0);
`endif
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("idle_busy_after_reset", 32'(busy), 32'd0);

        // Operation after reset works normally.
        issue(32'h00000010, 32'h00000020, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
